// File: rtl/dm_pkg.sv
// Shared widths, FSM state type and word encode/check helpers for the
// data-memory responder.
package dm_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int LAT_W  = 3;

  typedef enum logic [1:0] {CLEAR, IDLE, RD_WAIT} dm_state_t;

  // Even parity: the stored bit makes the whole 33-bit word carry an even number of ones.
  function automatic logic [DATA_W:0] dm_encode(input logic [DATA_W-1:0] d);
    return {^d, d};
  endfunction

  function automatic logic dm_parity_bad(input logic [DATA_W:0] w);
    return ^w;
  endfunction
endpackage

// File: rtl/data_mem_resp_if.sv
// DM_* request/response bundle between the CPU (master) and the data memory (slave).
interface data_mem_resp_if;
  import dm_pkg::*;

  logic              DM_enable;
  logic              DM_read;
  logic              DM_write;
  logic [ADDR_W-1:0] DM_address;
  logic [DATA_W-1:0] DM_in;
  logic [DATA_W-1:0] DM_out;
  logic              DM_valid;
  logic              DM_ready;
  logic              DM_perr;

  modport master (
    output DM_enable, DM_read, DM_write, DM_address, DM_in,
    input  DM_out, DM_valid, DM_ready, DM_perr
  );

  modport slave (
    input  DM_enable, DM_read, DM_write, DM_address, DM_in,
    output DM_out, DM_valid, DM_ready, DM_perr
  );
endinterface

// File: rtl/dm_sram_array.sv
// Storage only: one synchronous write port and one combinational read port.
// Out-of-range indices are never presented for write; reads beyond DEPTH are masked by the caller.
module dm_sram_array #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 32,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: self-clears after reset, then serves single-cycle writes and
// fixed-latency reads. Define DM_PARITY_EN to store and check an even-parity bit per word.
module data_mem_resp
  import dm_pkg::*;
#(
  parameter int DEPTH      = 4096,
  parameter int RD_LATENCY = 1
) (
  input logic           clk,
  input logic           rst,
  data_mem_resp_if.slave dm
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  dm_state_t         state, state_n;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_n;
  logic [ADDR_W-1:0] raddr, raddr_n;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_n;
  logic [DATA_W-1:0] out_q, out_n;
  logic              valid_q, valid_n;
  logic              perr_q, perr_n;

  logic              we;
  logic [AW-1:0]     waddr;
  logic [MEM_W-1:0]  wdata, rdata, req_word;
  logic              req_in_range, rd_in_range, rd_perr;

  assign req_in_range = 32'(dm.DM_address) < DEPTH;
  assign rd_in_range  = 32'(raddr) < DEPTH;

`ifdef DM_PARITY_EN
  assign req_word = dm_encode(dm.DM_in);
  assign rd_perr  = dm_parity_bad(rdata);
`else
  assign req_word = dm.DM_in;
  assign rd_perr  = 1'b0;
`endif

  dm_sram_array #(.DEPTH(DEPTH), .WIDTH(MEM_W), .AW(AW)) u_sram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr[AW-1:0]),
    .rdata (rdata)
  );

  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    raddr_n   = raddr;
    lat_cnt_n = lat_cnt;
    out_n     = out_q;
    valid_n   = 1'b0;
    perr_n    = 1'b0;
    we        = 1'b0;
    waddr     = '0;
    wdata     = '0;
    case (state)
      CLEAR: begin
        // Clear writer owns the array port; all-zero word also has parity 0.
        we    = 1'b1;
        waddr = clr_cnt[AW-1:0];
        if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
          state_n   = IDLE;
          clr_cnt_n = '0;
        end else begin
          clr_cnt_n = clr_cnt + 1'b1;
        end
      end
      IDLE: begin
        if (dm.DM_enable) begin
          if (dm.DM_write) begin
            // Write wins over a simultaneous read; out-of-range writes are dropped.
            we    = req_in_range;
            waddr = dm.DM_address[AW-1:0];
            wdata = req_word;
          end else if (dm.DM_read) begin
            raddr_n   = dm.DM_address;
            lat_cnt_n = LAT_W'(1);
            state_n   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        lat_cnt_n = lat_cnt + 1'b1;
        if (lat_cnt == LAT_W'(RD_LATENCY)) begin
          out_n   = rd_in_range ? rdata[DATA_W-1:0] : '0;
          perr_n  = rd_in_range & rd_perr;
          valid_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      raddr   <= '0;
      lat_cnt <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
      raddr   <= raddr_n;
      lat_cnt <= lat_cnt_n;
      out_q   <= out_n;
      valid_q <= valid_n;
      perr_q  <= perr_n;
    end
  end

  assign dm.DM_ready = (state == IDLE);
  assign dm.DM_out   = out_q;
  assign dm.DM_valid = valid_q;
  assign dm.DM_perr  = perr_q;
endmodule
